// File: rtl/data_ram_pkg.sv
// Shared word/byte geometry for the dual-port byte-writable data memory.
// Also holds the default depth and a byte-lane extraction helper.
package data_ram_pkg;

    localparam int WORD_W           = 32;
    localparam int BYTE_W           = 8;
    localparam int BYTES_PER_WORD   = WORD_W / BYTE_W;
    localparam int PORT_ADDR_W      = 30;
    localparam int DEFAULT_ADDR_LEN = 12;

    typedef logic [BYTES_PER_WORD-1:0] byte_en_t;
    typedef logic [WORD_W-1:0]         word_t;

    function automatic logic [BYTE_W-1:0] lane_byte(input word_t w, input int lane);
        return w[lane*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One 8-bit byte lane of the data memory: true dual-port, read-first, registered outputs.
// When both ports write the same address in one cycle, port A's byte wins.
module data_ram_lane
    import data_ram_pkg::*;
#(
    parameter int ADDR_LEN = DEFAULT_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_a,
    input  logic [ADDR_LEN-1:0] addr_a,
    input  logic [BYTE_W-1:0]   din_a,
    output logic [BYTE_W-1:0]   dout_a,
    input  logic                we_b,
    input  logic [ADDR_LEN-1:0] addr_b,
    input  logic [BYTE_W-1:0]   din_b,
    output logic [BYTE_W-1:0]   dout_b
);

    localparam int DEPTH = 1 << ADDR_LEN;

    logic [BYTE_W-1:0] mem_q [DEPTH];

    logic              wr_a_d;
    logic              wr_b_d;
    logic [BYTE_W-1:0] dout_a_d;
    logic [BYTE_W-1:0] dout_b_d;
    logic [BYTE_W-1:0] dout_a_q;
    logic [BYTE_W-1:0] dout_b_q;

    always_comb begin
        wr_a_d   = we_a & rst_n;
        wr_b_d   = we_b & rst_n;
        dout_a_d = mem_q[addr_a];
        dout_b_d = mem_q[addr_b];
    end

    // No reset on the array so it stays inferable as block RAM; A is written last so it wins.
    always_ff @(posedge clk) begin
        if (wr_b_d) begin
            mem_q[addr_b] <= din_b;
        end
        if (wr_a_d) begin
            mem_q[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/data_ram.sv
// True dual-port byte-writable 32-bit data memory: port A for the MEM stage, port B for debug/host.
// Only the low ADDR_LEN word-address bits select a word, so higher addresses alias.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_LEN = DEFAULT_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BYTES_PER_WORD-1:0] wea,
    input  logic [PORT_ADDR_W-1:0]    addra,
    input  logic [WORD_W-1:0]         dina,
    output logic [WORD_W-1:0]         douta,
    input  logic [BYTES_PER_WORD-1:0] web,
    input  logic [PORT_ADDR_W-1:0]    addrb,
    input  logic [WORD_W-1:0]         dinb,
    output logic [WORD_W-1:0]         doutb
);

    logic [ADDR_LEN-1:0] idx_a;
    logic [ADDR_LEN-1:0] idx_b;
    logic                addr_hi_unused;
    logic [BYTE_W-1:0]   douta_lane [BYTES_PER_WORD];
    logic [BYTE_W-1:0]   doutb_lane [BYTES_PER_WORD];

    always_comb begin
        idx_a          = addra[ADDR_LEN-1:0];
        idx_b          = addrb[ADDR_LEN-1:0];
        addr_hi_unused = ^{addra[PORT_ADDR_W-1:ADDR_LEN], addrb[PORT_ADDR_W-1:ADDR_LEN]};
    end

    for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
        data_ram_lane #(
            .ADDR_LEN (ADDR_LEN)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_a   (wea[g]),
            .addr_a (idx_a),
            .din_a  (lane_byte(dina, g)),
            .dout_a (douta_lane[g]),
            .we_b   (web[g]),
            .addr_b (idx_b),
            .din_b  (lane_byte(dinb, g)),
            .dout_b (doutb_lane[g])
        );
    end

    always_comb begin
        douta = '0;
        doutb = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            douta[i*BYTE_W +: BYTE_W] = douta_lane[i];
            doutb[i*BYTE_W +: BYTE_W] = doutb_lane[i];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: reset checks, a directed vector table, a mid-run reset sequence,
// and randomized traffic compared against a word-array reference model.
module tb_data_ram;

    localparam int ADDR_LEN = 12;
    localparam int DEPTH    = 1 << ADDR_LEN;

    logic        clk;
    logic        rst_n;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [3:0]  web;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;

    int total;
    int bad;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] m_exp_a;
    logic [31:0] m_exp_b;

    typedef struct {
        logic [3:0]  wa;
        logic [29:0] aa;
        logic [31:0] da;
        logic [3:0]  wb;
        logic [29:0] ab;
        logic [31:0] db;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [16];

    data_ram #(
        .ADDR_LEN (ADDR_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    // Reference: reads see the memory before this cycle's writes; B applied before A so A wins overlaps.
    task automatic model_step(input logic rst, input logic [3:0] wa, input logic [29:0] aa,
                              input logic [31:0] da, input logic [3:0] wb, input logic [29:0] ab,
                              input logic [31:0] db);
        int ia;
        int ib;
        logic [31:0] ma;
        logic [31:0] mb;
        ia = int'(aa % DEPTH);
        ib = int'(ab % DEPTH);
        if (!rst) begin
            m_exp_a = 32'h0;
            m_exp_b = 32'h0;
        end else begin
            m_exp_a = ref_mem[ia];
            m_exp_b = ref_mem[ib];
            ma = lane_mask(wa);
            mb = lane_mask(wb);
            ref_mem[ib] = (ref_mem[ib] & ~mb) | (db & mb);
            ref_mem[ia] = (ref_mem[ia] & ~ma) | (da & ma);
        end
    endtask

    task automatic apply(input logic [3:0] wa, input logic [29:0] aa, input logic [31:0] da,
                         input logic [3:0] wb, input logic [29:0] ab, input logic [31:0] db);
        wea   = wa;
        addra = aa;
        dina  = da;
        web   = wb;
        addrb = ab;
        dinb  = db;
        model_step(rst_n, wa, aa, da, wb, ab, db);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] rand_addr();
        logic [29:0] a;
        a = 30'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) a = a | (30'($urandom()) << ADDR_LEN);
        return a;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        // Directed vectors; expectations are the outputs right after each edge.
        vecs[0]  = '{4'hF, 30'd3,          32'h12345678, 4'h0, 30'd3,    32'h0,        32'h0,        32'h0};
        vecs[1]  = '{4'h0, 30'd3,          32'h0,        4'h0, 30'd3,    32'h0,        32'h12345678, 32'h12345678};
        vecs[2]  = '{4'hF, 30'd7,          32'hAABBCCDD, 4'h0, 30'd7,    32'h0,        32'h0,        32'h0};
        vecs[3]  = '{4'h4, 30'd7,          32'h00EE0000, 4'h0, 30'd7,    32'h0,        32'hAABBCCDD, 32'hAABBCCDD};
        vecs[4]  = '{4'h3, 30'd7,          32'h00001122, 4'h0, 30'd7,    32'h0,        32'hAAEECCDD, 32'hAAEECCDD};
        vecs[5]  = '{4'h0, 30'd7,          32'h0,        4'h0, 30'd7,    32'h0,        32'hAAEE1122, 32'hAAEE1122};
        vecs[6]  = '{4'hF, 30'd9,          32'h00000001, 4'h0, 30'd9,    32'h0,        32'h0,        32'h0};
        vecs[7]  = '{4'hF, 30'd9,          32'h00000002, 4'h0, 30'd9,    32'h0,        32'h1,        32'h1};
        vecs[8]  = '{4'h0, 30'd9,          32'h0,        4'h0, 30'd3,    32'h0,        32'h2,        32'h12345678};
        vecs[9]  = '{4'h3, 30'd4,          32'h0000AAAA, 4'h6, 30'd4,    32'h00BBBB00, 32'h0,        32'h0};
        vecs[10] = '{4'h0, 30'd4,          32'h0,        4'h0, 30'd4,    32'h0,        32'h00BBAAAA, 32'h00BBAAAA};
        vecs[11] = '{4'h0, 30'd1,          32'h0,        4'hF, 30'd4097, 32'hCAFEF00D, 32'h0,        32'h0};
        vecs[12] = '{4'h0, 30'd1,          32'h0,        4'h0, 30'd1,    32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vecs[13] = '{4'h0, 30'h3FFFF001,   32'h0,        4'h0, 30'd4,    32'h0,        32'hCAFEF00D, 32'h00BBAAAA};
        vecs[14] = '{4'h0, 30'd3,          32'h0,        4'h9, 30'd3,    32'hFF0000EE, 32'h12345678, 32'h12345678};
        vecs[15] = '{4'h0, 30'd3,          32'h0,        4'h0, 30'd3,    32'h0,        32'hFF3456EE, 32'hFF3456EE};

        // Reset held two cycles with a full-word write pending: outputs zero, write dropped.
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            apply(4'hF, 30'd5, 32'hDEADBEEF, 4'h0, 30'd5, 32'h0);
            check("reset_douta", douta, 32'h0);
            check("reset_doutb", doutb, 32'h0);
        end
        rst_n = 1'b1;
        apply(4'h0, 30'd5, 32'h0, 4'h0, 30'd5, 32'h0);
        check("post_reset_addr5_a", douta, 32'h0);
        check("post_reset_addr5_b", doutb, 32'h0);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].wb, vecs[i].ab, vecs[i].db);
            check($sformatf("vec%0d_douta", i), douta, vecs[i].exp_a);
            check($sformatf("vec%0d_doutb", i), doutb, vecs[i].exp_b);
        end

        // Mid-run reset: both ports try to write word 3; outputs clear, storage keeps its value.
        rst_n = 1'b0;
        apply(4'hF, 30'd3, 32'h55555555, 4'hF, 30'd3, 32'h66666666);
        check("midreset_douta", douta, 32'h0);
        check("midreset_doutb", doutb, 32'h0);
        rst_n = 1'b1;
        apply(4'h0, 30'd3, 32'h0, 4'h0, 30'd3, 32'h0);
        check("after_midreset_douta", douta, 32'hFF3456EE);
        check("after_midreset_doutb", doutb, 32'hFF3456EE);

        // Randomized traffic on a small address window so collisions and aliasing are frequent.
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            apply(4'($urandom_range(0, 15)), rand_addr(), $urandom(),
                  4'($urandom_range(0, 15)), rand_addr(), $urandom());
            check("rand_douta", douta, m_exp_a);
            check("rand_doutb", doutb, m_exp_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
